load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/lsu_store_align.sv | 54 +++++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

  // Memory command payload held for the duration of an access
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lsu_store_align.sv
// Byte-enable and write-lane generation plus access legality check.
module lsu_store_align
  import load_store_unit_pkg::*;
(
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_wdata,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_legal
);

  logic w_half_ok;
  logic w_word_ok;

  // A halfword may start at any offset that keeps it inside the word
  assign w_half_ok = (i_offset != 2'd3);
  assign w_word_ok = (i_offset == 2'd0);

  // Decode size, lanes and legality from funct3 and the byte offset
  always_comb begin
    o_be    = '1;
    o_wdata = '0;
    o_legal = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_SB: begin
          o_legal = 1'b1;
          o_be    = BE_W'(4'b0001 << i_offset);
          o_wdata = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_legal = w_half_ok;
          o_be    = BE_W'(4'b0011 << i_offset);
          o_wdata = {16'h0000, i_wdata[15:0]} << {i_offset, 3'b000};
        end
        F3_SW: begin
          o_legal = w_word_ok;
          o_wdata = i_wdata;
        end
        default: o_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        F3_LB, F3_LBU: o_legal = 1'b1;
        F3_LH, F3_LHU: o_legal = w_half_ok;
        F3_LW:         o_legal = w_word_ok;
        default:       o_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core request port to a word memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] rsp_addr,
  output logic [2:0]      rsp_funct3,
  output logic            rsp_err
);

  localparam int unsigned      CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t      r_state;
  lsu_state_t      w_state_next;
  logic            w_err_next;
  logic [CNT_W-1:0] r_cnt;
  mem_cmd_t        r_cmd;
  logic            r_req_ready;
  logic            r_mem_valid;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_rsp_data;
  logic [XLEN-1:0] r_rsp_addr;
  logic [2:0]      r_rsp_funct3;

  logic            w_accept;
  logic            w_capture;
  logic            w_timeout;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_legal;

  lsu_store_align u_align (
    .i_we     (req_we),
    .i_funct3 (req_funct3),
    .i_offset (req_addr[1:0]),
    .i_wdata  (req_wdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_legal  (w_legal)
  );

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_capture = (r_state == WAIT_RSP) && mem_rvalid;
  assign w_timeout = (r_cnt == CNT_LIMIT);

  // Next-state decode; the awaited strobe takes priority over the timeout
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_legal) begin
            w_state_next = ISSUE;
          end else begin
            w_state_next = RESP;
            w_err_next   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          w_state_next = r_cmd.we ? RESP : WAIT_RSP;
        end else if (w_timeout) begin
          w_state_next = RESP;
          w_err_next   = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          w_state_next = RESP;
        end else if (w_timeout) begin
          w_state_next = RESP;
          w_err_next   = 1'b1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Timeout counter: cleared on any state change, counts while waiting on memory
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ISSUE) || (r_state == WAIT_RSP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Handshake and response strobes registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == IDLE);
      r_mem_valid <= (w_state_next == ISSUE);
      r_rsp_valid <= (w_state_next == RESP);
      if (w_state_next == RESP) r_rsp_err <= w_err_next;
    end
  end

  // Request capture on accept and read data capture on the response strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd        <= '0;
      r_rsp_addr   <= '0;
      r_rsp_funct3 <= '0;
      r_rsp_data   <= '0;
    end else begin
      if (w_accept) begin
        r_cmd.addr   <= {req_addr[XLEN-1:2], 2'b00};
        r_cmd.we     <= req_we;
        r_cmd.be     <= w_be;
        r_cmd.wdata  <= w_wdata;
        r_rsp_addr   <= req_addr;
        r_rsp_funct3 <= req_funct3;
      end
      if (w_capture) r_rsp_data <= mem_rdata;
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_cmd.addr;
  assign mem_we     = r_cmd.we;
  assign mem_be     = r_cmd.be;
  assign mem_wdata  = r_cmd.wdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_data   = r_rsp_data;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_funct3 = r_rsp_funct3;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

  localparam int unsigned T     = 8;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data, rsp_addr;
  logic [2:0]  rsp_funct3;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_data;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_funct3 (rsp_funct3),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Access size in bytes (3 maps to 8, which can never fit and so is illegal)
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal_of(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit known;
    known = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return known && (int'(addr[1:0]) + size_of(f3) <= 4);
  endfunction

  function automatic logic [3:0] be_of(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = size_of(f3);
    if (!we) return 4'hF;
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] wd);
    case (size_of(f3))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return (wd & 32'h0000FFFF) << (8 * int'(addr[1:0]));
      default: return wd;
    endcase
  endfunction

  // One complete transaction with a scripted memory: rdy stall cycles, rv read wait cycles
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int rdy, input int rv, input logic [31:0] rdata);
    bit          legal, exp_err, hs, done;
    int          exp_lat, c, n_iss, n_wait;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    legal = legal_of(we, f3, addr);
    ebe   = be_of(we, f3, addr);
    ewd   = wdata_of(f3, addr, wd);
    eaddr = addr & 32'hFFFFFFFC;
    exp_err = 1'b0;
    if (!legal) begin
      exp_lat = 1; exp_err = 1'b1;
    end else if (rdy + 1 > int'(T)) begin
      exp_lat = 1 + int'(T); exp_err = 1'b1;
    end else if (we) begin
      exp_lat = rdy + 2;
    end else if (rv + 1 > int'(T)) begin
      exp_lat = rdy + 2 + int'(T); exp_err = 1'b1;
    end else begin
      exp_lat = rdy + rv + 3;
    end

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    c = 0; n_iss = 0; n_wait = 0; hs = 1'b0; done = 1'b0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid) begin
        done = 1'b1;
        if (legal && !we && !exp_err) exp_data = rdata;
        check("latency", 32'(c), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_addr", rsp_addr, addr);
        check("rsp_funct3", 32'(rsp_funct3), 32'(f3));
        check("rsp_data", rsp_data, exp_data);
        check("mem_issued", 32'(n_iss != 0), 32'(legal));
        mem_rvalid = 1'b1;
      end else if (mem_valid) begin
        check("mem_valid_after_hs", 32'(hs), 32'd0);
        check("mem_addr", mem_addr, eaddr);
        check("mem_be", 32'(mem_be), 32'(ebe));
        check("mem_we", 32'(mem_we), 32'(we));
        if (we) check("mem_wdata", mem_wdata, ewd);
        n_iss++;
        if (n_iss == rdy + 1) begin
          mem_ready = 1'b1;
          hs = 1'b1;
        end
        mem_rvalid = 1'($urandom);
      end else if (hs && !we) begin
        n_wait++;
        if (n_wait == rv + 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
      end
    end
    check("rsp_seen", 32'(done), 32'd1);
    if (done) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      check("rsp_data_hold", rsp_data, exp_data);
      check("req_ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  // Reset while a load waits for its read data; the late response must be dropped
  task automatic reset_mid_access();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mem_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_in_wait", 32'(mem_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_data = '0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_rsp_addr", rsp_addr, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rst_late_rvalid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, exp_data);
    end
  endtask

  initial begin
    int          rdy, rv;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_data = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_addr", rsp_addr, 32'd0);
    check("reset_rsp_funct3", 32'(rsp_funct3), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0);
    txn(1'b1, 3'b001, 32'h302, 32'h00001234, 5, 0, 32'h0);
    txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11111111);
    txn(1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h22222222);
    txn(1'b0, 3'b010, 32'h104, 32'h0, 2, NEVER, 32'h33333333);
    txn(1'b0, 3'b010, 32'h108, 32'h0, 0, int'(T) - 1, 32'h44444444);
    txn(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, int'(T) - 1, 0, 32'h0);
    txn(1'b1, 3'b010, 32'h110, 32'hCAFEF00D, int'(T), 0, 32'h0);
    txn(1'b0, 3'b101, 32'h112, 32'h0, int'(T), 0, 32'h55555555);
    txn(1'b1, 3'b100, 32'h114, 32'h0, 0, 0, 32'h0);
    txn(1'b0, 3'b110, 32'h118, 32'h0, 0, 0, 32'h0);
    reset_mid_access();

    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      rdy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2));
      rv  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 9));
      txn(1'($urandom), 3'($urandom), a, $urandom, rdy, rv, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
